// File: rtl/pipe_delay_line.sv
// Valid-tagged multi-channel delay line with runtime depth, stall and flush.
// Output is taken from stage depth_q-1; depth only changes while the window is empty.
module pipe_delay_line #(
   parameter int REG_W    = 8,
   parameter int N_CH     = 2,
   parameter int MAX_D    = 4,
   parameter int CLR_DATA = 1,
   localparam int DSEL_W  = $clog2(MAX_D + 1),
   localparam int OCC_W   = $clog2(MAX_D + 1),
   localparam int BUS_W   = N_CH * REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic [DSEL_W-1:0] depth_sel,
   input  logic              in_valid,
   input  logic [BUS_W-1:0]  in_data,
   output logic              out_valid,
   output logic [BUS_W-1:0]  out_data,
   output logic [OCC_W-1:0]  occupancy,
   output logic [DSEL_W-1:0] depth_q
);

   logic [MAX_D-1:0]  r_vld;
   logic [BUS_W-1:0]  r_dat [MAX_D];
   logic [OCC_W-1:0]  r_occ;
   logic [DSEL_W-1:0] r_depth;

   logic [DSEL_W-1:0] w_dclamp;
   logic [MAX_D-1:0]  w_win;
   logic [MAX_D-1:0]  w_vld_in;
   logic [BUS_W-1:0]  w_dat_in [MAX_D];
   logic              w_out_vld;
   logic [BUS_W-1:0]  w_out_dat;

   always_comb begin
      w_dclamp = depth_sel;
      if (depth_sel == '0)
         w_dclamp = DSEL_W'(1);
      else if (depth_sel > DSEL_W'(MAX_D))
         w_dclamp = DSEL_W'(MAX_D);
   end

   // Stages at or beyond the applied depth are outside the window and never hold a valid bit.
   always_comb begin
      w_win = '0;
      for (int k = 0; k < MAX_D; k++)
         w_win[k] = (DSEL_W'(k) < r_depth);
   end

   always_comb begin
      w_vld_in[0] = in_valid;
      w_dat_in[0] = in_data;
      for (int k = 1; k < MAX_D; k++) begin
         w_vld_in[k] = r_vld[k-1];
         w_dat_in[k] = r_dat[k-1];
      end
   end

   always_comb begin
      w_out_vld = 1'b0;
      w_out_dat = '0;
      for (int k = 0; k < MAX_D; k++) begin
         if (r_depth == DSEL_W'(k + 1)) begin
            w_out_vld = r_vld[k];
            w_out_dat = r_dat[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= '0;
         r_occ   <= '0;
         r_depth <= w_dclamp;
         for (int k = 0; k < MAX_D; k++)
            r_dat[k] <= '0;
      end else begin
         // Depth may only move with an empty window so no entry is reordered or duplicated.
         if (r_occ == '0)
            r_depth <= w_dclamp;
         if (flush) begin
            r_vld <= '0;
            r_occ <= '0;
            if (CLR_DATA != 0) begin
               for (int k = 0; k < MAX_D; k++)
                  r_dat[k] <= '0;
            end
         end else if (en) begin
            r_vld <= w_vld_in & w_win;
            for (int k = 0; k < MAX_D; k++)
               r_dat[k] <= w_dat_in[k];
            r_occ <= r_occ + OCC_W'(in_valid) - OCC_W'(w_out_vld);
         end
      end
   end

   assign out_valid = w_out_vld;
   assign out_data  = w_out_dat;
   assign occupancy = r_occ;
   assign depth_q   = r_depth;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed self-checking bench for pipe_delay_line (REG_W=8, N_CH=2, MAX_D=4, CLR_DATA=1).
module tb_pipe_delay_line;

   logic        clk;
   logic        rst;
   logic        en;
   logic        flush;
   logic [2:0]  depth_sel;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_valid;
   logic [15:0] out_data;
   logic [2:0]  occupancy;
   logic [2:0]  depth_q;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_delay_line #(
      .REG_W(8), .N_CH(2), .MAX_D(4), .CLR_DATA(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .depth_sel (depth_sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .occupancy (occupancy),
      .depth_q   (depth_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a_v;
      rst = 1'b1; en = 1'b1; flush = 1'b0; depth_sel = 3'd3;
      in_valid = 1'b0; in_data = 16'h0;

      // reset
      step(); step();
      chk("rst_vld",   out_valid, 0);
      chk("rst_data",  out_data,  0);
      chk("rst_occ",   occupancy, 0);
      chk("rst_depth", depth_q,   3);

      // latency 3 stream k=1..6
      rst = 1'b0; in_valid = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         in_data = 16'(n);
         step();
         chk("lat_occ",  occupancy, (n < 3) ? n : 3);
         chk("lat_vld",  out_valid, (n >= 3) ? 1 : 0);
         chk("lat_data", out_data,  (n >= 3) ? n - 2 : 0);
      end

      // stall for 4 cycles; new input must not be captured
      en = 1'b0; in_data = 16'd99;
      for (int n = 0; n < 4; n++) begin
         step();
         chk("stall_vld",  out_valid, 1);
         chk("stall_data", out_data,  4);
         chk("stall_occ",  occupancy, 3);
      end
      en = 1'b1;
      for (int j = 0; j < 3; j++) begin
         in_data = 16'(7 + j);
         step();
         chk("resume_data", out_data,  5 + j);
         chk("resume_occ",  occupancy, 3);
      end

      // flush with a valid input on the same edge
      flush = 1'b1; in_valid = 1'b1; in_data = 16'h0055;
      step();
      chk("flush_vld",   out_valid, 0);
      chk("flush_data",  out_data,  0);
      chk("flush_occ",   occupancy, 0);
      chk("flush_depth", depth_q,   3);
      flush = 1'b0; in_valid = 1'b0; in_data = 16'h0;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("post_flush_vld",  out_valid, 0);
         chk("post_flush_data", out_data,  0);
      end

      // depth change gating
      depth_sel = 3'd2;
      step();
      chk("d_to2", depth_q, 2);
      in_valid = 1'b1; in_data = 16'h00A1;
      step();
      chk("d_in_occ", occupancy, 1);
      chk("d_in_vld", out_valid, 0);
      in_valid = 1'b0; in_data = 16'h0; depth_sel = 3'd4;
      step();
      chk("d_hold_depth", depth_q,   2);
      chk("d_hold_vld",   out_valid, 1);
      chk("d_hold_data",  out_data,  16'h00A1);
      chk("d_hold_occ",   occupancy, 1);
      step();
      chk("d_drain_depth", depth_q,   2);
      chk("d_drain_occ",   occupancy, 0);
      chk("d_drain_vld",   out_valid, 0);
      step();
      chk("d_to4",     depth_q,   4);
      chk("d_to4_vld", out_valid, 0);
      in_valid = 1'b1; in_data = 16'h00B2;
      step();
      chk("d4_e1_vld", out_valid, 0);
      chk("d4_e1_occ", occupancy, 1);
      in_valid = 1'b0; in_data = 16'h0;
      step();
      chk("d4_e2_vld", out_valid, 0);
      step();
      chk("d4_e3_vld", out_valid, 0);
      step();
      chk("d4_e4_vld",  out_valid, 1);
      chk("d4_e4_data", out_data,  16'h00B2);
      chk("d4_e4_occ",  occupancy, 1);
      step();
      chk("d4_e5_vld", out_valid, 0);
      chk("d4_e5_occ", occupancy, 0);

      // clamping, including a change on a stalled edge
      en = 1'b0; depth_sel = 3'd0;
      step();
      chk("clamp0", depth_q, 1);
      en = 1'b1; depth_sel = 3'd7;
      step();
      chk("clamp7", depth_q, 4);

      // depth 1 with full-window retire
      depth_sel = 3'd1;
      step();
      chk("d1_depth", depth_q, 1);
      in_valid = 1'b1; in_data = 16'h0033;
      step();
      chk("d1_a_vld",  out_valid, 1);
      chk("d1_a_data", out_data,  16'h0033);
      chk("d1_a_occ",  occupancy, 1);
      in_data = 16'h0044;
      step();
      chk("d1_b_data", out_data,  16'h0044);
      chk("d1_b_occ",  occupancy, 1);
      in_valid = 1'b0; in_data = 16'h0;
      step();
      chk("d1_c_vld", out_valid, 0);
      chk("d1_c_occ", occupancy, 0);

      // paired channels with alternating bubbles at depth 2
      depth_sel = 3'd2;
      step();
      chk("mc_depth", depth_q, 2);
      for (int n = 0; n < 6; n++) begin
         a_v      = 8'(8'h10 + n);
         in_valid = ((n % 2) == 0);
         in_data  = {~a_v, a_v};
         step();
         chk("mc_occ", occupancy, 1);
         if (n >= 1) begin
            a_v = 8'(8'h10 + n - 1);
            chk("mc_vld",  out_valid, (((n - 1) % 2) == 0) ? 1 : 0);
            chk("mc_data", out_data,  {16'h0, ~a_v, a_v});
         end
      end

      // reset with data in flight overrides the depth gate
      rst = 1'b1; depth_sel = 3'd3; in_valid = 1'b0; in_data = 16'h0;
      step();
      chk("mrst_occ",   occupancy, 0);
      chk("mrst_vld",   out_valid, 0);
      chk("mrst_data",  out_data,  0);
      chk("mrst_depth", depth_q,   3);
      rst = 1'b0; in_valid = 1'b1; in_data = 16'h0077;
      step();
      chk("mrst_e1_vld", out_valid, 0);
      in_valid = 1'b0; in_data = 16'h0;
      step();
      chk("mrst_e2_vld", out_valid, 0);
      step();
      chk("mrst_e3_vld",  out_valid, 1);
      chk("mrst_e3_data", out_data,  16'h0077);
      chk("mrst_e3_occ",  occupancy, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_delay_line.md
Name: pipe_delay_line

Overview:
Multi-channel, valid-tagged delay line with runtime-selectable depth, clock-enable stall and synchronous flush. It is the parametrised successor of the fixed-depth pipe register used to align operands with multiplier latency. Typical use: operand/result alignment next to optmult, where latency changes with multiplier configuration and the pipeline must stall or drain.

Parameters:
REG_W, 8, data width per channel (>=1)
N_CH, 2, number of channels sharing one valid tag (>=1)
MAX_D, 4, maximum delay in stages (>=1)
CLR_DATA, 1, 1: flush also zeroes data registers; 0: flush clears valid bits only
(derived) DSEL_W = $clog2(MAX_D+1), OCC_W = $clog2(MAX_D+1), BUS_W = N_CH*REG_W

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  advance enable; 0 = stall, all stages hold
flush  in  1  synchronous pipeline clear
depth_sel  in  DSEL_W  requested depth
in_valid  in  1  input tag
in_data  in  BUS_W  channel i at [i*REG_W +: REG_W]
out_valid  out  1  valid tag of the output stage
out_data  out  BUS_W  data of the output stage
occupancy  out  OCC_W  valid entries inside the active window
depth_q  out  DSEL_W  currently applied depth (1..MAX_D)

Behaviour:
- Storage: stages s[0..MAX_D-1], each holding {valid, BUS_W data}. No combinational path from in_* to out_*.
- Effective depth: clamp(depth_sel) = 1 if 0, MAX_D if >MAX_D, else depth_sel.
- Priority per edge: rst > flush > en.
- rst: all valid bits = 0, all data = 0, occupancy = 0, depth_q = clamp(depth_sel). Outputs after reset: out_valid=0, out_data=0, occupancy=0.
- flush (rst=0): all valid bits = 0, occupancy = 0. Data is zeroed if CLR_DATA=1, held if CLR_DATA=0. The in_valid/in_data sampled on the flush cycle are dropped. en is ignored on that cycle.
- en=1 (no rst/flush): s[0] <= {in_valid, in_data}; s[k] <= s[k-1] for k=1..MAX_D-1.
- en=0: every stage holds, and outputs and occupancy are unchanged. Inputs are not captured.
- Output: {out_valid, out_data} = s[depth_q-1].
- Latency: D = depth_q enabled edges. With en held high, a sample presented at edge t appears at the outputs after edge t+D-1, and is readable in the cycle following that edge. For D=3 this matches the legacy 3-deep pipe.
- Window masking: valid bits of stages with index >= depth_q are forced to 0 every edge. Stale entries therefore never reappear when depth increases.
- Depth change: depth_q <= clamp(depth_sel) on any non-reset edge where occupancy==0 at that edge (pre-update value). This includes flush edges and stalled edges. Otherwise depth_sel is ignored and depth_q holds. Data is never reordered or duplicated by a depth change.
- occupancy: incremental, occ <= occ + (en & in_valid) - (en & out_valid) when no rst/flush. It must always equal the popcount of valid bits in s[0..depth_q-1] and never exceed depth_q.
- Full window (occupancy==depth_q) with en=1 and in_valid=1: the output entry retires in the same edge, so occupancy stays at depth_q. There is no backpressure port; the consumer must accept out_* whenever en=1.
- Bubbles: in_valid=0 entries propagate as holes. Their data still shifts, but out_valid=0 for them.
- Reset mid-operation: all in-flight entries are discarded, and the first output after reset follows the full latency rule.

Test Plan:
- Reset/latency: rst 2 cycles, depth_sel=3, en=1, in_valid=1, in_data=k (k=1,2,…) -> out_valid=0 and out_data=0 until the 3rd post-reset edge, then out_data=1,2,… in order; occupancy ramps 1,2,3 and holds at 3.
- Stall: stream 10,11,12 at depth 2, en=0 for 4 cycles mid-stream -> out_data and occupancy frozen during the stall; the sequence resumes with no loss or duplicate; total elapsed cycles = 2 + 4 + count.
- Flush: occupancy=3 at depth 3 with CLR_DATA=1, assert flush together with in_valid=1 and in_data=0x55 -> next cycle out_valid=0, out_data=0, occupancy=0; 0x55 never appears at the output.
- Depth change gating: depth_q=2 with data in flight, depth_sel=4 -> depth_q stays 2 until the pipeline drains, becomes 4 on the first empty edge, and the next sample has latency 4; depth_sel=0 -> depth_q=1; depth_sel=7 (MAX_D=4) -> depth_q=4.
- Multi-channel/bubbles: N_CH=2, alternate in_valid 1/0 with ch0=a, ch1=~a -> channels stay paired at the output; out_valid pattern is 1,0,1,0 delayed by D; occupancy never exceeds ceil(D/2)+1.
- Scoreboard random: random en, in_valid, flush (5%) and depth_sel over 10k cycles vs a reference queue model -> out_* exact match, and occupancy == popcount of the window on every cycle.
